priority_decoder_seq: RTL and testbench

//  Sequential decoder for the 2-bit priority code {y1,y0,valid} that the priority encoder produces.
//  - Accepts codes over a valid/ready handshake and buffers one code.
//  - Drives the matching one-hot line d3..d0 for a programmable number of cycles.
//  - Inserts an optional idle gap between consecutive decoded pulses.
//  - Sits downstream of the encoder and turns arbitrated requests back into timed per-line strobes.

---
 rtl/priority_decoder_seq.sv | 130 +++++++++++++
 tb/tb_priority_decoder_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_decoder_seq.sv
// Sequential decoder for the 2-bit priority code {y1,y0,valid}.
// Buffers one code over a valid/ready handshake. Drives the matching one-hot
// line for HOLD_CYCLES cycles, then optionally holds all lines low for
// GAP_CYCLES cycles before the next pulse.
module priority_decoder_seq #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y1,
    input  logic y0,
    input  logic valid,
    output logic ready,
    output logic d3,
    output logic d2,
    output logic d1,
    output logic d0,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Counter reload values; the counter runs down to zero, so load N-1.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  =
        CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic [1:0]       code_q, code_d;
    logic [3:0]       line_q, line_d;
    logic             done_q, done_d;

    // Map a 2-bit code onto its one-hot output line.
    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    // Next-state logic: buffer capture plus the IDLE/DRIVE/GAP sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        code_d      = code_q;
        line_d      = line_q;
        done_d      = 1'b0;

        // Capture only when the buffer is empty; a consume never coincides.
        if (valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            code_d      = {y1, y0};
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d     = DRIVE;
                    line_d      = onehot(code_q);
                    cnt_d       = HOLD_LOAD;
                    hold_full_d = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done_d = 1'b1;
                    if (HAS_GAP) begin
                        state_d = GAP;
                        line_d  = 4'b0000;
                        cnt_d   = GAP_LOAD;
                    end else if (hold_full_q) begin
                        // Back-to-back pulse: swap the active line in one edge.
                        line_d      = onehot(code_q);
                        cnt_d       = HOLD_LOAD;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        line_d  = 4'b0000;
                    end
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 4'b0000;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            code_q      <= 2'b00;
            line_q      <= 4'b0000;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            code_q      <= code_d;
            line_q      <= line_d;
            done_q      <= done_d;
        end
    end

    assign ready            = ~hold_full_q;
    assign busy             = (state_q != IDLE) || hold_full_q;
    assign {d3, d2, d1, d0} = line_q;
    assign done             = done_q;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Scoreboard bench for priority_decoder_seq: three instances with different
// hold/gap settings share stimulus lines; each has its own expected-code queue
// and a monitor that checks pulse codes, lengths, done and one-hot-ness.
module tb_priority_decoder_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic y1 = 1'b0;
    logic y0 = 1'b0;
    logic valid = 1'b0;
    int   sel = 0;

    logic [2:0][3:0] d_w;
    logic [2:0]      ready_w;
    logic [2:0]      busy_w;
    logic [2:0]      done_w;

    int errors = 0;
    int checks = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] q2[$];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic q_push(input int idx, input logic [1:0] c);
        case (idx)
            0:       q0.push_back(c);
            1:       q1.push_back(c);
            default: q2.push_back(c);
        endcase
    endtask

    function automatic int q_size(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_pop(input int idx, output logic [1:0] c);
        case (idx)
            0:       c = q0.pop_front();
            1:       c = q1.pop_front();
            default: c = q2.pop_front();
        endcase
    endtask

    task automatic q_flush(input int idx);
        case (idx)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned H = (gi == 0) ? 4 : (gi == 1) ? 2 : 1;
        localparam int unsigned G = (gi == 0) ? 1 : 0;

        logic d3_w, d2_w, d1_w, d0_w, rdy_w, bsy_w, dn_w;

        priority_decoder_seq #(
            .HOLD_CYCLES(H),
            .GAP_CYCLES (G),
            .CNT_W      (8)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .y1   (y1),
            .y0   (y0),
            .valid(valid && (sel == gi)),
            .ready(rdy_w),
            .d3   (d3_w),
            .d2   (d2_w),
            .d1   (d1_w),
            .d0   (d0_w),
            .busy (bsy_w),
            .done (dn_w)
        );

        assign d_w[gi]     = {d3_w, d2_w, d1_w, d0_w};
        assign ready_w[gi] = rdy_w;
        assign busy_w[gi]  = bsy_w;
        assign done_w[gi]  = dn_w;

        logic [3:0] prev_d = 4'b0000;
        int         run = 0;
        logic       rst_prev = 1'b0;

        // Monitor: reconstruct pulses from the one-hot lines and score them.
        always @(negedge clk) begin
            logic [3:0] cur;
            logic       end_p;
            logic [1:0] expc;
            cur = d_w[gi];
            chk($sformatf("onehot[%0d]", gi), int'($countones(cur) <= 1), 1);
            if (!rst_prev) begin
                chk($sformatf("rst_d[%0d]", gi), int'(cur), 0);
                chk($sformatf("rst_done[%0d]", gi), int'(done_w[gi]), 0);
                q_flush(gi);
                prev_d = 4'b0000;
                run    = 0;
            end else begin
                end_p = (prev_d != 4'b0000) && ((cur != prev_d) || (run == int'(H)));
                chk($sformatf("done[%0d]", gi), int'(done_w[gi]), int'(end_p));
                if (end_p) begin
                    if (q_size(gi) == 0) begin
                        chk($sformatf("unexpected_pulse[%0d]", gi), int'(prev_d), 0);
                    end else begin
                        q_pop(gi, expc);
                        chk($sformatf("pulse_code[%0d]", gi), int'(prev_d),
                            int'(4'b0001 << expc));
                        chk($sformatf("pulse_len[%0d]", gi), run, int'(H));
                    end
                end
                if (cur == 4'b0000)               run = 0;
                else if (end_p || cur != prev_d)  run = 1;
                else                              run = run + 1;
                prev_d = cur;
            end
            rst_prev = rst_n;
        end
    end

    // Offer one code to instance idx, holding valid until it is taken.
    task automatic send(input int idx, input logic [1:0] c);
        int waited;
        waited = 0;
        sel   = idx;
        y1    = c[1];
        y0    = c[0];
        valid = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_w[idx]) break;
            waited++;
            if (waited > 100) begin
                chk($sformatf("send_timeout[%0d]", idx), 0, 1);
                valid = 1'b0;
                return;
            end
        end
        q_push(idx, c);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk($sformatf("ready_after_accept[%0d]", idx), int'(ready_w[idx]), 0);
        chk($sformatf("busy_after_accept[%0d]", idx), int'(busy_w[idx]), 1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for 3 edges with valid asserted: nothing is captured.
        sel = 0; y1 = 1'b1; y0 = 1'b0; valid = 1'b1; rst_n = 1'b0;
        step(3);
        valid = 1'b0; rst_n = 1'b1;
        chk("reset_ready", int'(ready_w[0]), 1);
        chk("reset_busy", int'(busy_w[0]), 0);
        chk("reset_d", int'(d_w[0]), 0);
        chk("reset_done", int'(done_w[0]), 0);
        step(3);
        chk("reset_nocapture_busy", int'(busy_w[0]), 0);

        // Single code 10 with HOLD=4, GAP=1: exact pulse timing.
        send(0, 2'b10);
        chk("t2_d_at_k", int'(d_w[0]), 0);
        step(1);
        chk("t2_d_k1", int'(d_w[0]), 4);
        chk("t2_ready_k1", int'(ready_w[0]), 1);
        step(3);
        chk("t2_d_k4", int'(d_w[0]), 4);
        step(1);
        chk("t2_d_k5", int'(d_w[0]), 0);
        chk("t2_done_k5", int'(done_w[0]), 1);
        chk("t2_busy_gap", int'(busy_w[0]), 1);
        step(1);
        chk("t2_done_k6", int'(done_w[0]), 0);
        chk("t2_busy_idle", int'(busy_w[0]), 0);
        step(2);

        // Back-to-back with HOLD=2, GAP=0, including a repeated code.
        send(1, 2'b11);
        send(1, 2'b00);
        send(1, 2'b01);
        send(1, 2'b01);
        step(12);
        chk("t3_idle_busy", int'(busy_w[1]), 0);

        // Back-pressure on the default instance.
        send(0, 2'b01);
        send(0, 2'b10);
        send(0, 2'b11);
        step(20);
        chk("t4_idle_busy", int'(busy_w[0]), 0);

        // Reset during the second cycle of a d1 pulse with 10 buffered.
        send(0, 2'b01);
        send(0, 2'b10);
        rst_n = 1'b0;
        step(1);
        chk("t5_d_after_rst", int'(d_w[0]), 0);
        chk("t5_done_after_rst", int'(done_w[0]), 0);
        chk("t5_ready_after_rst", int'(ready_w[0]), 1);
        rst_n = 1'b1;
        step(12);
        chk("t5_busy_after", int'(busy_w[0]), 0);

        // valid low with code 00 present: ignored.
        sel = 0; y1 = 1'b0; y0 = 1'b0; valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t6_idle_busy", int'(busy_w[0]), 0);
        end

        // HOLD=1: single-cycle strobes.
        send(2, 2'b00);
        step(1);
        chk("t6_h1_d0", int'(d_w[2]), 1);
        step(1);
        chk("t6_h1_low", int'(d_w[2]), 0);
        chk("t6_h1_done", int'(done_w[2]), 1);
        send(2, 2'b00);
        send(2, 2'b11);
        step(10);

        chk("q0_drained", q_size(0), 0);
        chk("q1_drained", q_size(1), 0);
        chk("q2_drained", q_size(2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
